// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU and load result handshakes, register
// file write port, and load FIFO occupancy.
// master: upstream side (drives results, sees readies and rf write).
// slave : the arbiter itself.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    input  alu_ready, mem_ready,
    input  rf_we, rf_waddr, rf_wdata, fifo_count
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    output alu_ready, mem_ready,
    output rf_we, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results (priority) and buffered
// load results into one registered register-file write port. A starvation
// limiter stalls the ALU for one cycle after STARVE_MAX consecutive losses
// by a non-empty load FIFO. Writes to r0 are accepted and dropped.
// Optional: define WB_BYPASS_EN to let a load skip an empty FIFO when the
// output slot is free (1-cycle load latency instead of 2).
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         resetn,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  SMAX = SC_W'(STARVE_MAX);

  // load FIFO storage and bookkeeping
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt;

  // registered write port
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  // per-cycle decisions
  logic              fifo_ne, alu_rdy, mem_rdy;
  logic              alu_acc, mem_acc, alu_wr, mem_nz;
  logic              byp, deq, enq, load_out;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  assign fifo_ne = (count != '0);
  // Full FIFO refuses even if the head leaves this cycle: no same-cycle reuse.
  assign mem_rdy = resetn && (count != FULL);
  assign alu_rdy = resetn && !((starve_cnt == SMAX) && fifo_ne);

  assign alu_acc = bus.alu_valid && alu_rdy;
  assign mem_acc = bus.mem_valid && mem_rdy;
  assign alu_wr  = alu_acc && (bus.alu_waddr != '0);
  assign mem_nz  = mem_acc && (bus.mem_waddr != '0);

`ifdef WB_BYPASS_EN
  // Empty FIFO and free slot: the load goes straight to the output register.
  assign byp = mem_nz && !fifo_ne && !alu_wr;
`else
  assign byp = 1'b0;
`endif

  assign deq      = fifo_ne && !alu_wr;
  assign enq      = mem_nz && !byp;
  assign load_out = alu_wr || deq || byp;

  // Output source select: ALU, else FIFO head, else bypassed load.
  always_comb begin
    out_addr = bus.alu_waddr;
    out_data = bus.alu_wdata;
    if (!alu_wr) begin
      if (deq) begin
        out_addr = q_addr[rd_ptr];
        out_data = q_data[rd_ptr];
      end else begin
        out_addr = bus.mem_waddr;
        out_data = bus.mem_wdata;
      end
    end
  end

  // FIFO payload; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= bus.mem_waddr;
      q_data[wr_ptr] <= bus.mem_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts consecutive ALU wins over a waiting FIFO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!fifo_ne || deq) begin
      starve_cnt <= '0;
    end else if (alu_wr) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= load_out;
      if (load_out) begin
        waddr_q <= out_addr;
        wdata_q <= out_data;
      end
    end
  end

  assign bus.alu_ready  = alu_rdy;
  assign bus.mem_ready  = mem_rdy;
  assign bus.rf_we      = we_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.fifo_count = count;
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file write port (we/waddr/wdata).
- Merges two result sources into the single write port:
  - single-cycle ALU results, which have priority;
  - load results from the memory stage, buffered in a small FIFO.
- Registered output drives the register file; a starvation limiter guarantees load results drain.

Parameters:
DATA_W, 32, result/write data width
ADDR_W, 5, register address width
DEPTH, 4, load FIFO entries; power of two, >= 2
STARVE_MAX, 3, consecutive cycles a non-empty FIFO may lose arbitration before the ALU is stalled for one cycle; >= 1

Ports:
clk  input  1  clock, all state updates on posedge
resetn  input  1  synchronous active-low reset
alu_valid  input  1  ALU result present
alu_ready  output  1  ALU result accepted this cycle when alu_valid && alu_ready
alu_waddr  input  ADDR_W  ALU destination register
alu_wdata  input  DATA_W  ALU result
mem_valid  input  1  load result present
mem_ready  output  1  load result accepted when mem_valid && mem_ready
mem_waddr  input  ADDR_W  load destination register
mem_wdata  input  DATA_W  load data
rf_we  output  1  register file write enable (registered)
rf_waddr  output  ADDR_W  register file write address (registered)
rf_wdata  output  DATA_W  register file write data (registered)
fifo_count  output  clog2(DEPTH)+1  current load FIFO occupancy

Behaviour:
- Reset:
  - Fixed: one clock, clk; reset is synchronous and active-low on resetn, sampled only at posedge clk.
  - While resetn=0, at the next edge: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO emptied (fifo_count=0), starve counter=0.
  - alu_ready=0 and mem_ready=0 combinationally whenever resetn=0.
  - Reset mid-operation discards all buffered loads and any pending output write.
- Handshakes:
  - mem_ready = resetn && (fifo_count != DEPTH).
  - alu_ready = resetn && !(starve_cnt == STARVE_MAX && fifo_count != 0).
  - Upstream must hold valid/data stable until accepted.
- Register zero:
  - Accepted results with waddr==0 are consumed and discarded.
  - An ALU result to r0 does not occupy the output slot that cycle.
  - A load to r0 is not enqueued.
- Arbitration per cycle, evaluated before the edge; exactly one source or none loads the output register:
  - 1) Accepted ALU result with waddr!=0 -> output register.
  - 2) Else FIFO non-empty -> head entry dequeued -> output register.
  - 3) Else rf_we=0 next cycle (address/data hold last values).
- Latency:
  - ALU accepted at edge N -> rf_we=1 with its addr/data after edge N; the register file writes at edge N+1.
  - Load accepted at edge N is enqueued at edge N; earliest dequeue is edge N+1, so rf_we=1 after edge N+1 (2-cycle latency).
- FIFO:
  - Circular buffer with read/write pointers wrapping at DEPTH.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Full: mem_ready=0 even if a dequeue occurs the same cycle (no same-cycle space reuse).
  - Empty: no dequeue.
  - Order among loads strictly preserved.
- Starvation counter starve_cnt (0..STARVE_MAX):
  - +1 at each edge where fifo_count!=0 and an ALU result took the slot.
  - Cleared on any dequeue or when fifo_count==0.
  - At STARVE_MAX, alu_ready=0 for that cycle and the FIFO head is written; the counter then clears.
- Ordering hazard (same register written by both sources) is resolved upstream; this block writes in arbitration order.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - A load accepted when fifo_count==0 and no accepted ALU result with waddr!=0 is present that cycle skips the FIFO.
  - It is loaded directly into the output register at the accept edge (1-cycle latency); fifo_count is unchanged.
- Undefined: all loads with waddr!=0 pass through the FIFO (2-cycle latency).

Test Plan:
- Reset, then alu_valid=1, waddr=3, wdata=0x1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234; alu_ready=1 throughout.
- Load waddr=5, data=0xA5A5 with no ALU traffic -> rf_we=1 for r5 two cycles after accept (one cycle with WB_BYPASS_EN), fifo_count peaks at 1 (0 with bypass).
- Continuous ALU stream plus 6 loads, DEPTH=4 -> mem_ready=0 once fifo_count=4; with STARVE_MAX=3, alu_ready drops every 4th cycle and loads appear on rf in accept order.
- ALU waddr=0 and load waddr=0, both accepted -> rf_we never asserted, fifo_count stays 0.
- Fill FIFO to 3, assert resetn=0 for one cycle -> fifo_count=0, rf_we=0, ready outputs 0 during reset, no buffered load ever written.
- Simultaneous ALU(r7) and load(r8) with FIFO empty -> r7 written first, r8 the following cycle; starve_cnt returns to 0.
